// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage plus MEM/WB pipeline register.
//   Resolves jump / taken-branch redirects combinationally from the M_* bundle,
//   performs the word-wide data-memory access, suppresses overflowing or
//   misaligned instructions, and registers the W_* write-back bundle.
// Ports:
//   Clk, Clrn            clock (state updates on falling edge), sync active-low reset
//   M_*                  EX/MEM bundle: targets, ALU flags/result, store data, control
//   PCsrc, Redirect_PC   redirect select (0 PC+4, 1 branch, 2 jump) and target
//   Flush                squash younger stages whenever a redirect is taken
//   W_*                  registered write-back bundle
//   Ovf_flag, Mis_flag   sticky exception flags; Exc_cnt saturating suppress count
module mem_wb_stage #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] M_Jtarg,
  input  logic [31:0] M_Btarg,
  input  logic        M_Zero,
  input  logic        M_Overflow,
  input  logic [31:0] M_ALUout,
  input  logic [31:0] M_busB,
  input  logic [4:0]  M_Rw,
  input  logic        M_Jump,
  input  logic        M_Branch,
  input  logic        M_MemWr,
  input  logic        M_RegWr,
  input  logic        M_MemtoReg,
  output logic [1:0]  PCsrc,
  output logic [31:0] Redirect_PC,
  output logic        Flush,
  output logic        W_RegWr,
  output logic        W_MemtoReg,
  output logic [4:0]  W_Rw,
  output logic [31:0] W_ALUout,
  output logic [31:0] W_Dout,
  output logic        Ovf_flag,
  output logic        Mis_flag,
  output logic [7:0]  Exc_cnt
);

  logic              mem_op;
  logic              mis;
  logic              ovf;
  logic              sup;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_data;

  logic [31:0] mem [DEPTH];

  logic        w_regwr_q, w_memtoreg_q;
  logic [4:0]  w_rw_q;
  logic [31:0] w_aluout_q, w_dout_q;
  logic        ovf_flag_q, mis_flag_q;
  logic [7:0]  exc_cnt_q;

  // Redirect: jump wins over taken branch; nothing redirects while in reset.
  always_comb begin
    PCsrc       = 2'd0;
    Redirect_PC = 32'd0;
    if (Clrn) begin
      if (M_Jump) begin
        PCsrc       = 2'd2;
        Redirect_PC = M_Jtarg;
      end else if (M_Branch && M_Zero) begin
        PCsrc       = 2'd1;
        Redirect_PC = M_Btarg;
      end
    end
  end

  assign Flush = (PCsrc != 2'd0);

  assign mem_op   = M_MemWr | M_MemtoReg;
  assign mis      = mem_op & (M_ALUout[1:0] != 2'b00);
  assign ovf      = M_Overflow & (M_RegWr | M_MemWr);
  assign sup      = mis | ovf;
  // Upper address bits are dropped, so accesses wrap modulo DEPTH words.
  assign word_idx = M_ALUout[ADDR_W+1:2];
  assign rd_data  = mem[word_idx];

  // Data memory is never cleared by reset; a store in a reset cycle is dropped.
  always_ff @(negedge Clk) begin
    if (Clrn && M_MemWr && !sup) begin
      mem[word_idx] <= M_busB;
    end
  end

  always_ff @(negedge Clk) begin
    if (!Clrn) begin
      w_regwr_q    <= 1'b0;
      w_memtoreg_q <= 1'b0;
      w_rw_q       <= 5'd0;
      w_aluout_q   <= 32'd0;
      w_dout_q     <= 32'd0;
      ovf_flag_q   <= 1'b0;
      mis_flag_q   <= 1'b0;
      exc_cnt_q    <= 8'd0;
    end else begin
      w_regwr_q    <= M_RegWr & ~sup;
      w_memtoreg_q <= M_MemtoReg & ~sup;
      w_rw_q       <= M_Rw;
      w_aluout_q   <= M_ALUout;
      // rd_data is sampled before the same-edge store lands: read-old on collision.
      w_dout_q     <= rd_data;
      if (ovf) ovf_flag_q <= 1'b1;
      if (mis) mis_flag_q <= 1'b1;
      if (sup && (exc_cnt_q != 8'hFF)) exc_cnt_q <= exc_cnt_q + 8'd1;
    end
  end

  assign W_RegWr    = w_regwr_q;
  assign W_MemtoReg = w_memtoreg_q;
  assign W_Rw       = w_rw_q;
  assign W_ALUout   = w_aluout_q;
  assign W_Dout     = w_dout_q;
  assign Ovf_flag   = ovf_flag_q;
  assign Mis_flag   = mis_flag_q;
  assign Exc_cnt    = exc_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed scenarios followed by random traffic,
// checked against a word-array reference model through an expected-result queue.
module tb_mem_wb_stage;

  localparam int unsigned DEPTH = 256;

  logic        Clk, Clrn;
  logic [31:0] M_Jtarg, M_Btarg, M_ALUout, M_busB;
  logic        M_Zero, M_Overflow, M_Jump, M_Branch, M_MemWr, M_RegWr, M_MemtoReg;
  logic [4:0]  M_Rw;
  logic [1:0]  PCsrc;
  logic [31:0] Redirect_PC, W_ALUout, W_Dout;
  logic        Flush, W_RegWr, W_MemtoReg, Ovf_flag, Mis_flag;
  logic [4:0]  W_Rw;
  logic [7:0]  Exc_cnt;

  mem_wb_stage #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .Clk(Clk), .Clrn(Clrn), .M_Jtarg(M_Jtarg), .M_Btarg(M_Btarg), .M_Zero(M_Zero),
    .M_Overflow(M_Overflow), .M_ALUout(M_ALUout), .M_busB(M_busB), .M_Rw(M_Rw),
    .M_Jump(M_Jump), .M_Branch(M_Branch), .M_MemWr(M_MemWr), .M_RegWr(M_RegWr),
    .M_MemtoReg(M_MemtoReg), .PCsrc(PCsrc), .Redirect_PC(Redirect_PC), .Flush(Flush),
    .W_RegWr(W_RegWr), .W_MemtoReg(W_MemtoReg), .W_Rw(W_Rw), .W_ALUout(W_ALUout),
    .W_Dout(W_Dout), .Ovf_flag(Ovf_flag), .Mis_flag(Mis_flag), .Exc_cnt(Exc_cnt)
  );

  typedef struct packed {
    logic        jump, branch, zero, ovf, memwr, regwr, memtoreg;
    logic [31:0] jt, bt, alu, busb;
    logic [4:0]  rw;
  } inst_t;

  typedef struct packed {
    logic        regwr, memtoreg;
    logic [4:0]  rw;
    logic [31:0] alu, dout;
    logic        of, mf;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl_mem [DEPTH];
  logic        mdl_of, mdl_mf;
  int          mdl_cnt;
  int          vectors = 0;
  int          errors  = 0;

  initial begin
    Clk = 1'b1;
    forever #5 Clk = ~Clk;
  end

  function automatic inst_t nop();
    inst_t i;
    i = '0;
    return i;
  endfunction

  // Issue one instruction for one cycle; Clrn=0 makes it a reset cycle.
  task automatic apply(input inst_t i, input logic rstn);
    exp_t        e;
    int          idx;
    int          exp_src;
    logic [31:0] exp_pc;
    logic        is_mis, is_ovf;
    @(posedge Clk);
    #2;
    Clrn = rstn;
    M_Jump = i.jump; M_Branch = i.branch; M_Zero = i.zero; M_Overflow = i.ovf;
    M_MemWr = i.memwr; M_RegWr = i.regwr; M_MemtoReg = i.memtoreg;
    M_Jtarg = i.jt; M_Btarg = i.bt; M_ALUout = i.alu; M_busB = i.busb; M_Rw = i.rw;
    #1;
    exp_src = 0;
    exp_pc  = 32'd0;
    if (rstn && i.jump) begin
      exp_src = 2; exp_pc = i.jt;
    end else if (rstn && i.branch && i.zero) begin
      exp_src = 1; exp_pc = i.bt;
    end
    vectors++;
    if (int'(PCsrc) != exp_src || Redirect_PC !== exp_pc || Flush !== (exp_src != 0)) begin
      errors++;
      $display("FAIL redirect: got src=%0d pc=%h flush=%b, want src=%0d pc=%h flush=%b",
               PCsrc, Redirect_PC, Flush, exp_src, exp_pc, exp_src != 0);
    end
    // Reference model of the write-back result.
    idx    = int'((i.alu / 4) % DEPTH);
    is_mis = (i.memwr || i.memtoreg) && (i.alu % 4 != 0);
    is_ovf = i.ovf && (i.regwr || i.memwr);
    if (!rstn) begin
      e = '0;
      mdl_of = 1'b0; mdl_mf = 1'b0; mdl_cnt = 0;
    end else begin
      e.regwr    = i.regwr && !(is_mis || is_ovf);
      e.memtoreg = i.memtoreg && !(is_mis || is_ovf);
      e.rw       = i.rw;
      e.alu      = i.alu;
      e.dout     = mdl_mem[idx];
      if (is_ovf) mdl_of = 1'b1;
      if (is_mis) mdl_mf = 1'b1;
      if ((is_mis || is_ovf) && mdl_cnt < 255) mdl_cnt++;
      e.of  = mdl_of;
      e.mf  = mdl_mf;
      e.cnt = 8'(mdl_cnt);
      if (i.memwr && !(is_mis || is_ovf)) mdl_mem[idx] = i.busb;
    end
    sb_q.push_back(e);
  endtask

  // Monitor: W_* is refreshed by every falling edge; compare just after the rising edge.
  initial begin
    exp_t e, g;
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = {W_RegWr, W_MemtoReg, W_Rw, W_ALUout, W_Dout, Ovf_flag, Mis_flag, Exc_cnt};
        vectors++;
        if (g !== e) begin
          errors++;
          $display("FAIL wb: got rw=%b m2r=%b rd=%0d alu=%h dout=%h of=%b mf=%b cnt=%0d; want rw=%b m2r=%b rd=%0d alu=%h dout=%h of=%b mf=%b cnt=%0d",
                   g.regwr, g.memtoreg, g.rw, g.alu, g.dout, g.of, g.mf, g.cnt,
                   e.regwr, e.memtoreg, e.rw, e.alu, e.dout, e.of, e.mf, e.cnt);
        end
      end
    end
  end

  function automatic inst_t st(input logic [31:0] a, input logic [31:0] d);
    inst_t i;
    i = nop(); i.memwr = 1'b1; i.alu = a; i.busb = d;
    return i;
  endfunction

  function automatic inst_t ld(input logic [31:0] a, input logic [4:0] rd);
    inst_t i;
    i = nop(); i.memtoreg = 1'b1; i.regwr = 1'b1; i.alu = a; i.rw = rd;
    return i;
  endfunction

  initial begin
    inst_t i;
    for (int k = 0; k < DEPTH; k++) mdl_mem[k] = 32'd0;
    mdl_of = 1'b0; mdl_mf = 1'b0; mdl_cnt = 0;
    Clrn = 1'b0;
    apply(nop(), 1'b0);
    apply(nop(), 1'b0);
    // Give the 16-word random pool defined contents.
    for (int k = 0; k < 16; k++) apply(st(32'(k * 4), $urandom), 1'b1);
    // Store then immediately load.
    apply(st(32'h10, 32'hDEADBEEF), 1'b1);
    apply(ld(32'h10, 5'd5), 1'b1);
    // Redirect priority.
    i = nop(); i.jump = 1; i.branch = 1; i.zero = 1; i.jt = 32'h400; i.bt = 32'h200;
    apply(i, 1'b1);
    i.jump = 0;
    apply(i, 1'b1);
    i.zero = 0;
    apply(i, 1'b1);
    // Misaligned store (same word as 0x10) must not write; then overflowing ADD.
    apply(st(32'h13, 32'h0BADF00D), 1'b1);
    apply(ld(32'h10, 5'd6), 1'b1);
    i = nop(); i.ovf = 1; i.regwr = 1; i.alu = 32'h7; i.rw = 5'd9;
    apply(i, 1'b1);
    // Saturation of the exception counter, then a one-edge reset.
    for (int k = 0; k < 300; k++) apply(i, 1'b1);
    apply(nop(), 1'b0);
    apply(ld(32'h10, 5'd1), 1'b1);
    // Store carried by a reset edge is discarded.
    apply(st(32'h20, 32'h12345678), 1'b0);
    apply(ld(32'h20, 5'd2), 1'b1);
    // Address wrap-around.
    apply(st(32'h10, 32'hCAFE0123), 1'b1);
    apply(ld(32'h410, 5'd3), 1'b1);
    // Random traffic over the pool, with random upper address bits.
    for (int k = 0; k < 400; k++) begin
      i.jump = 1'($urandom_range(0, 7) == 0);
      i.branch = 1'($urandom); i.zero = 1'($urandom);
      i.ovf = 1'($urandom_range(0, 5) == 0);
      i.memwr = 1'($urandom); i.memtoreg = 1'($urandom); i.regwr = 1'($urandom);
      i.jt = $urandom; i.bt = $urandom; i.busb = $urandom; i.rw = 5'($urandom);
      i.alu = {22'($urandom), 4'b0000, 4'($urandom),
               ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00};
      apply(i, 1'($urandom_range(0, 40) != 0));
    end
    apply(nop(), 1'b1);
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge Clk);
    #2;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
